// File: rtl/led_matrix_sink_if.sv
// Pixel-stream bus between the game scan engine (master) and the LED matrix sink (slave).
interface led_matrix_sink_if;
    logic [2:0] xIn;
    logic [3:0] yIn;
    logic [2:0] colorIn;
    logic       wrEn;
    logic       clearReq;
    logic       swapReq;
    logic       frameDone;
    logic       busy;

    modport master (
        output xIn, yIn, colorIn, wrEn, clearReq, swapReq,
        input  frameDone, busy
    );

    modport slave (
        input  xIn, yIn, colorIn, wrEn, clearReq, swapReq,
        output frameDone, busy
    );
endinterface

// File: rtl/led_matrix_sink.sv
// LED matrix sink: 8x16 x 3-bit frame buffer fed by a pixel write stream,
// with a clear engine and a row-multiplexed refresh (LOAD / SHOW / BLANK).
// Optional macro DOUBLE_BUFFER_EN: front/back buffers swapped at frame wrap.
module led_matrix_sink #(
    parameter int unsigned REFRESH_DIV  = 10000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    led_matrix_sink_if.slave  pix,
    output logic [15:0]       rowSel,
    output logic [7:0]        colR,
    output logic [7:0]        colG,
    output logic [7:0]        colB
);

    localparam int unsigned COLS  = 8;
    localparam int unsigned ROWS  = 16;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = 7;
    localparam int unsigned PW    = 16;
    localparam int unsigned CW    = 3;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [0:0] CLR_IDLE = 1'b0;
    localparam logic [0:0] CLR_RUN  = 1'b1;

    // refresh state
    logic [1:0]             ref_state_q, ref_state_d;
    logic [3:0]             row_q, row_d;
    logic [PW-1:0]          pres_q, pres_d;
    logic [COLS-1:0][CW-1:0] shadow_q, shadow_d;
    logic [ROWS-1:0]        row_sel_q, row_sel_d;
    logic [COLS-1:0]        col_r_q, col_r_d;
    logic [COLS-1:0]        col_g_q, col_g_d;
    logic [COLS-1:0]        col_b_q, col_b_d;
    logic                   frame_done_q, frame_done_d;

    // clear engine state
    logic [0:0]             clr_state_q, clr_state_d;
    logic [AW-1:0]          clr_addr_q, clr_addr_d;
    logic                   busy_q, busy_d;

    // buffer access
    logic                   fb_we_c;
    logic [AW-1:0]          fb_waddr_c;
    logic [CW-1:0]          fb_wdata_c;
    logic [2:0]             col_c;
    logic [AW-1:0]          fb_raddr_c;
    logic [CW-1:0]          fb_rdata_c;

    assign col_c      = pres_q[2:0];
    assign fb_raddr_c = {row_q, col_c};

`ifdef DOUBLE_BUFFER_EN
    logic [CW-1:0] fb0_q [CELLS];
    logic [CW-1:0] fb1_q [CELLS];
    logic          front_q, front_d;
    logic          swap_pend_q, swap_pend_d;
    logic          swap_now_c;
    logic          front_rd_c;

    // swap fires in the frameDone cycle; the read mux already sees the new front
    assign swap_now_c = frame_done_q & (swap_pend_q | pix.swapReq);
    assign front_rd_c = front_q ^ swap_now_c;
    assign fb_rdata_c = front_rd_c ? fb1_q[fb_raddr_c] : fb0_q[fb_raddr_c];

    // swap bookkeeping: a request is held until the next frame wrap
    always_comb begin
        front_d     = front_q ^ swap_now_c;
        swap_pend_d = swap_now_c ? 1'b0 : (swap_pend_q | pix.swapReq);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            front_q     <= front_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    // buffer 0 storage; written only while it is the back buffer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(CELLS); i++) fb0_q[i] <= '0;
        end else if (fb_we_c && front_q) begin
            fb0_q[fb_waddr_c] <= fb_wdata_c;
        end
    end

    // buffer 1 storage; written only while it is the back buffer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(CELLS); i++) fb1_q[i] <= '0;
        end else if (fb_we_c && !front_q) begin
            fb1_q[fb_waddr_c] <= fb_wdata_c;
        end
    end
`else
    logic [CW-1:0] fb_q [CELLS];
    logic          swap_unused;

    assign swap_unused = pix.swapReq;
    assign fb_rdata_c  = fb_q[fb_raddr_c];

    // single shared buffer; a same-cycle read sees the pre-write value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(CELLS); i++) fb_q[i] <= '0;
        end else if (fb_we_c) begin
            fb_q[fb_waddr_c] <= fb_wdata_c;
        end
    end
`endif

    // clear engine next state and buffer write port arbitration
    always_comb begin
        clr_state_d = clr_state_q;
        clr_addr_d  = clr_addr_q;
        busy_d      = busy_q;
        fb_we_c     = 1'b0;
        fb_waddr_c  = '0;
        fb_wdata_c  = '0;
        case (clr_state_q)
            CLR_IDLE: begin
                if (pix.wrEn) begin
                    fb_we_c    = 1'b1;
                    fb_waddr_c = {pix.yIn, pix.xIn};
                    fb_wdata_c = pix.colorIn;
                end
                if (pix.clearReq) begin
                    clr_state_d = CLR_RUN;
                    clr_addr_d  = '0;
                    busy_d      = 1'b1;
                end
            end
            CLR_RUN: begin
                fb_we_c    = 1'b1;
                fb_waddr_c = clr_addr_q;
                fb_wdata_c = '0;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(CELLS - 1)) begin
                    clr_state_d = CLR_IDLE;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                clr_state_d = CLR_IDLE;
                busy_d      = 1'b0;
            end
        endcase
    end

    // refresh FSM next state and LED drive
    always_comb begin
        ref_state_d  = ref_state_q;
        row_d        = row_q;
        pres_d       = pres_q + PW'(1);
        shadow_d     = shadow_q;
        row_sel_d    = row_sel_q;
        col_r_d      = col_r_q;
        col_g_d      = col_g_q;
        col_b_d      = col_b_q;
        frame_done_d = 1'b0;
        case (ref_state_q)
            ST_LOAD: begin
                row_sel_d       = '0;
                shadow_d[col_c] = fb_rdata_c;
                if (pres_q == PW'(COLS - 1)) begin
                    ref_state_d = ST_SHOW;
                    pres_d      = '0;
                    row_sel_d   = ROWS'(1) << row_q;
                    for (int c = 0; c < int'(COLS); c++) begin
                        col_r_d[c] = shadow_d[c][2];
                        col_g_d[c] = shadow_d[c][1];
                        col_b_d[c] = shadow_d[c][0];
                    end
                end
            end
            ST_SHOW: begin
                if (pres_q == PW'(REFRESH_DIV - 1)) begin
                    ref_state_d = ST_BLANK;
                    pres_d      = '0;
                    row_sel_d   = '0;
                end
            end
            ST_BLANK: begin
                row_sel_d = '0;
                if (pres_q == PW'(BLANK_CYCLES - 1)) begin
                    ref_state_d  = ST_LOAD;
                    pres_d       = '0;
                    row_d        = row_q + 4'd1;
                    frame_done_d = (row_q == 4'd15);
                end
            end
            default: begin
                ref_state_d = ST_LOAD;
                pres_d      = '0;
                row_sel_d   = '0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_state_q  <= ST_LOAD;
            row_q        <= '0;
            pres_q       <= '0;
            shadow_q     <= '0;
            row_sel_q    <= '0;
            col_r_q      <= '0;
            col_g_q      <= '0;
            col_b_q      <= '0;
            frame_done_q <= 1'b0;
            clr_state_q  <= CLR_IDLE;
            clr_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            ref_state_q  <= ref_state_d;
            row_q        <= row_d;
            pres_q       <= pres_d;
            shadow_q     <= shadow_d;
            row_sel_q    <= row_sel_d;
            col_r_q      <= col_r_d;
            col_g_q      <= col_g_d;
            col_b_q      <= col_b_d;
            frame_done_q <= frame_done_d;
            clr_state_q  <= clr_state_d;
            clr_addr_q   <= clr_addr_d;
            busy_q       <= busy_d;
        end
    end

    assign rowSel        = row_sel_q;
    assign colR          = col_r_q;
    assign colG          = col_g_q;
    assign colB          = col_b_q;
    assign pix.frameDone = frame_done_q;
    assign pix.busy      = busy_q;

endmodule

// File: tb/tb_led_matrix_sink.sv
// Directed bench for led_matrix_sink with REFRESH_DIV=4, BLANK_CYCLES=2 (row period 14, frame 224).
module tb_led_matrix_sink;

    logic        clk;
    logic        rst;
    logic [15:0] row_sel;
    logic [7:0]  col_r;
    logic [7:0]  col_g;
    logic [7:0]  col_b;
    int          n_checks;
    int          n_errors;
    int          cyc;

    led_matrix_sink_if pix ();

    led_matrix_sink #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .pix    (pix),
        .rowSel (row_sel),
        .colR   (col_r),
        .colG   (col_g),
        .colB   (col_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic write_px(input logic [2:0] x, input logic [3:0] y, input logic [2:0] c);
        pix.xIn     = x;
        pix.yIn     = y;
        pix.colorIn = c;
        pix.wrEn    = 1'b1;
        tick();
        pix.wrEn    = 1'b0;
    endtask

    // expected rowSel from the absolute cycle count after reset release
    function automatic logic [15:0] exp_row_sel(input int c);
        int ph;
        int r;
        logic [15:0] one;
        ph  = c % 14;
        r   = (c / 14) % 16;
        one = 16'h0001;
        if (ph >= 8 && ph < 12) return one << r;
        return 16'h0000;
    endfunction

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        rst          = 1'b1;
        pix.xIn      = '0;
        pix.yIn      = '0;
        pix.colorIn  = '0;
        pix.wrEn     = 1'b0;
        pix.clearReq = 1'b0;
        pix.swapReq  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rowsel", 32'(row_sel), 32'h0);
        check("rst_cols", 32'({col_r, col_g, col_b}), 32'h0);
        check("rst_framedone", 32'(pix.frameDone), 32'h0);
        check("rst_busy", 32'(pix.busy), 32'h0);

        rst = 1'b0;
        cyc = 0;

        // first frame: row scan timing, dark columns, frameDone at 224
        while (cyc <= 230) begin
`ifndef DOUBLE_BUFFER_EN
            if (cyc == 100) begin
                pix.xIn = 3'd3; pix.yIn = 4'd0; pix.colorIn = 3'b101; pix.wrEn = 1'b1;
            end
            if (cyc == 101) pix.wrEn = 1'b0;
`endif
            check("scan_rowsel", 32'(row_sel), 32'(exp_row_sel(cyc)));
            check("scan_framedone", 32'(pix.frameDone), (cyc == 224) ? 32'h1 : 32'h0);
            check("scan_cols", 32'({col_r, col_g, col_b}), 32'h0);
            check("scan_busy", 32'(pix.busy), 32'h0);
            tick();
        end

`ifndef DOUBLE_BUFFER_EN
        // row 0 of frame 1 shows pixel (3,0)=101
        run_to(233);
        check("r0_rowsel", 32'(row_sel), 32'h0001);
        check("r0_colr", 32'(col_r), 32'h08);
        check("r0_colg", 32'(col_g), 32'h00);
        check("r0_colb", 32'(col_b), 32'h08);

        // corner pixel (7,15)=111 and frame wrap pulse
        run_to(240);
        write_px(3'd7, 4'd15, 3'b111);
        run_to(443);
        check("r15_rowsel", 32'(row_sel), 32'h8000);
        check("r15_colr", 32'(col_r), 32'h80);
        check("r15_colg", 32'(col_g), 32'h80);
        check("r15_colb", 32'(col_b), 32'h80);
        run_to(446);
        check("blank_rowsel", 32'(row_sel), 32'h0);
        check("blank_hold", 32'(col_r), 32'h80);
        run_to(447);
        check("fd_before", 32'(pix.frameDone), 32'h0);
        tick();
        check("fd_pulse", 32'(pix.frameDone), 32'h1);
        tick();
        check("fd_after", 32'(pix.frameDone), 32'h0);

        // fill every cell with green, then clear
        run_to(450);
        for (int i = 0; i < 128; i++) begin
            pix.xIn     = 3'(i % 8);
            pix.yIn     = 4'(i / 8);
            pix.colorIn = 3'b010;
            pix.wrEn    = 1'b1;
            tick();
        end
        pix.wrEn = 1'b0;
        check("clr_req_busy", 32'(pix.busy), 32'h0);
        pix.clearReq = 1'b1;
        tick();
        pix.clearReq = 1'b0;
        check("clr_busy_rise", 32'(pix.busy), 32'h1);
        run_to(597);
        check("fill_r10_colg", 32'(col_g), 32'hFF);
        check("fill_r10_colr", 32'(col_r), 32'h00);
        run_to(600);
        write_px(3'd0, 4'd0, 3'b111);
        run_to(706);
        check("clr_busy_last", 32'(pix.busy), 32'h1);
        tick();
        check("clr_busy_fall", 32'(pix.busy), 32'h0);
        for (int r = 0; r < 16; r++) begin
            run_to(896 + r * 14 + 9);
            check($sformatf("clr_colg_r%0d", r), 32'(col_g), 32'h0);
            check($sformatf("clr_colr_r%0d", r), 32'(col_r), 32'h0);
        end

        // write collides with LOAD read of (2,5): old value first, new next frame
        run_to(1192);
        write_px(3'd2, 4'd5, 3'b001);
        run_to(1199);
        check("coll_rowsel", 32'(row_sel), 32'h0020);
        check("coll_old", 32'(col_b), 32'h00);
        run_to(1423);
        check("coll_new", 32'(col_b), 32'h04);
`else
        // back-buffer write stays hidden until a swap at the frame wrap
        run_to(240);
        write_px(3'd0, 4'd0, 3'b100);
        run_to(457);
        check("db_rowsel", 32'(row_sel), 32'h0001);
        check("db_noswap", 32'(col_r), 32'h00);
        run_to(460);
        pix.swapReq = 1'b1;
        tick();
        pix.swapReq = 1'b0;
        run_to(672);
        check("db_fd", 32'(pix.frameDone), 32'h1);
        run_to(681);
        check("db_swapped", 32'(col_r), 32'h01);
`endif

        // asynchronous reset in the middle of SHOW
        #2;
        rst = 1'b1;
        #1;
        check("async_rowsel", 32'(row_sel), 32'h0);
        check("async_cols", 32'({col_r, col_g, col_b}), 32'h0);
        check("async_busy", 32'(pix.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
